// File: rtl/conv1d_window_gen_if.sv
// Streaming sample handshake plus window outputs for conv1d_window_gen.
// The master drives samples in; the slave (the window generator) answers with ready and windows.
interface conv1d_window_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_ready;
    logic                  win_valid;
    logic [DATA_WIDTH-1:0] win0;
    logic [DATA_WIDTH-1:0] win1;
    logic [DATA_WIDTH-1:0] win2;
    logic                  seq_done;
    logic                  err_short;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, win_valid, win0, win1, win2, seq_done, err_short
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, win_valid, win0, win1, win2, seq_done, err_short
    );
endinterface

// File: rtl/conv1d_window_gen.sv
// Builds 3-sample sliding windows from a framed sample stream for the 3-tap systolic array,
// with optional zero padding at both ends of each sequence and a configurable stride.
module conv1d_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int STRIDE     = 1,
    parameter int PAD        = 0
) (
    input logic               clk,
    input logic               rst_n,
    conv1d_window_gen_if.slave bus
);

    typedef enum logic [1:0] {ST_STREAM, ST_FLUSH, ST_END} state_t;

    localparam logic [1:0] LP_LAST_PHASE = 2'(STRIDE - 1);
    localparam logic       LP_PAD        = (PAD != 0);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_t0, r_t1, r_t2;
    logic [1:0]            r_fill;
    logic [1:0]            r_phase;
    logic                  r_s_ready;
    logic                  r_win_valid;
    logic [DATA_WIDTH-1:0] r_win0, r_win1, r_win2;
    logic                  r_seq_done;
    logic                  r_err_short;

    logic                  w_accept;
    logic                  w_shift;
    logic                  w_last_acc;
    logic                  w_first_pad;
    logic [1:0]            w_fill_cur;
    logic [1:0]            w_phase_cur;
    logic [1:0]            w_fill_base;
    logic [1:0]            w_fill_nxt;
    logic [1:0]            w_phase_nxt;
    logic                  w_elig;
    logic                  w_emit;
    logic                  w_end_seq;
    logic [DATA_WIDTH-1:0] w_n0, w_n1, w_n2;

    // END already counts as a cleared sequence, so a sample taken there starts the next one.
    always_comb begin
        w_accept    = bus.s_valid && r_s_ready;
        w_shift     = w_accept || (r_state == ST_FLUSH);
        w_last_acc  = w_accept && bus.s_last;
        w_fill_cur  = (r_state == ST_END) ? 2'd0 : r_fill;
        w_phase_cur = (r_state == ST_END) ? 2'd0 : r_phase;
        w_first_pad = LP_PAD && w_accept && (w_fill_cur == 2'd0);

        w_n0 = w_first_pad ? '0 : r_t1;
        w_n1 = w_first_pad ? '0 : r_t2;
        w_n2 = (r_state == ST_FLUSH) ? '0 : bus.s_data;

        w_fill_base = w_first_pad ? 2'd1 : w_fill_cur;
        w_fill_nxt  = (w_fill_base == 2'd3) ? 2'd3 : w_fill_base + 2'd1;
        w_elig      = (w_fill_nxt == 2'd3);
        w_emit      = w_shift && w_elig && (w_phase_cur == 2'd0);

        w_phase_nxt = w_phase_cur;
        if (w_elig) begin
            w_phase_nxt = (w_phase_cur == LP_LAST_PHASE) ? 2'd0 : w_phase_cur + 2'd1;
        end

        w_end_seq = (r_state == ST_FLUSH) || (w_last_acc && !LP_PAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_STREAM;
            r_t0        <= '0;
            r_t1        <= '0;
            r_t2        <= '0;
            r_fill      <= 2'd0;
            r_phase     <= 2'd0;
            r_s_ready   <= 1'b1;
            r_win_valid <= 1'b0;
            r_win0      <= '0;
            r_win1      <= '0;
            r_win2      <= '0;
            r_seq_done  <= 1'b0;
            r_err_short <= 1'b0;
        end else begin
            if (w_shift) begin
                r_t0    <= w_n0;
                r_t1    <= w_n1;
                r_t2    <= w_n2;
                r_fill  <= w_fill_nxt;
                r_phase <= w_phase_nxt;
            end else if (r_state == ST_END) begin
                r_fill  <= 2'd0;
                r_phase <= 2'd0;
            end

            r_win_valid <= w_emit;
            if (w_emit) begin
                r_win0 <= w_n0;
                r_win1 <= w_n1;
                r_win2 <= w_n2;
            end

            // A sequence that ends before the taps ever fill has produced no window at all.
            r_seq_done  <= w_end_seq;
            r_err_short <= w_end_seq && (w_fill_nxt != 2'd3);

            if (r_state == ST_FLUSH) begin
                r_state   <= ST_END;
                r_s_ready <= 1'b1;
            end else if (w_last_acc) begin
                r_state   <= LP_PAD ? ST_FLUSH : ST_END;
                r_s_ready <= !LP_PAD;
            end else begin
                r_state   <= ST_STREAM;
                r_s_ready <= 1'b1;
            end
        end
    end

    assign bus.s_ready   = r_s_ready;
    assign bus.win_valid = r_win_valid;
    assign bus.win0      = r_win0;
    assign bus.win1      = r_win1;
    assign bus.win2      = r_win2;
    assign bus.seq_done  = r_seq_done;
    assign bus.err_short = r_err_short;

endmodule

// File: tb/tb_conv1d_window_gen.sv
// Directed bench for conv1d_window_gen: three instances (PAD0/STRIDE1, PAD1/STRIDE1, PAD0/STRIDE2)
// share one stimulus source; a negedge monitor logs every output event for comparison.
module tb_conv1d_window_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    int         sel;
    logic       tValid;
    logic [7:0] tData;
    logic       tLast;

    int vectors     = 0;
    int miscompares = 0;
    int readyLow    = 0;

    logic        obsValid, obsDone, obsErr, obsReady;
    logic [23:0] obsWin;

    logic [26:0] logQ[$];
    logic [26:0] expQ[$];

    always #5 clk = ~clk;

    conv1d_window_gen_if #(.DATA_WIDTH(8)) busA ();
    conv1d_window_gen_if #(.DATA_WIDTH(8)) busB ();
    conv1d_window_gen_if #(.DATA_WIDTH(8)) busC ();

    assign busA.s_valid = tValid && (sel == 0);
    assign busB.s_valid = tValid && (sel == 1);
    assign busC.s_valid = tValid && (sel == 2);
    assign busA.s_data  = tData;
    assign busB.s_data  = tData;
    assign busC.s_data  = tData;
    assign busA.s_last  = tLast;
    assign busB.s_last  = tLast;
    assign busC.s_last  = tLast;

    conv1d_window_gen #(.DATA_WIDTH(8), .STRIDE(1), .PAD(0)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
    conv1d_window_gen #(.DATA_WIDTH(8), .STRIDE(1), .PAD(1)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));
    conv1d_window_gen #(.DATA_WIDTH(8), .STRIDE(2), .PAD(0)) dutC (.clk(clk), .rst_n(rst_n), .bus(busC));

    always_comb begin
        obsValid = busA.win_valid;
        obsDone  = busA.seq_done;
        obsErr   = busA.err_short;
        obsReady = busA.s_ready;
        obsWin   = {busA.win0, busA.win1, busA.win2};
        case (sel)
            1: begin
                obsValid = busB.win_valid;
                obsDone  = busB.seq_done;
                obsErr   = busB.err_short;
                obsReady = busB.s_ready;
                obsWin   = {busB.win0, busB.win1, busB.win2};
            end
            2: begin
                obsValid = busC.win_valid;
                obsDone  = busC.seq_done;
                obsErr   = busC.err_short;
                obsReady = busC.s_ready;
                obsWin   = {busC.win0, busC.win1, busC.win2};
            end
            default: ;
        endcase
    end

    // Window contents are only meaningful while win_valid is high, so they are masked otherwise.
    always @(negedge clk) begin
        if (obsValid || obsDone || obsErr)
            logQ.push_back({obsValid, obsDone, obsErr, obsValid ? obsWin : 24'h0});
        if (!obsReady)
            readyLow++;
    end

    function automatic logic [26:0] ent(logic v, logic d, logic e, int a, int b, int c);
        return {v, d, e, 8'(a), 8'(b), 8'(c)};
    endfunction

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkLog(string tag);
        int n;
        checkOutput({tag, "_event_count"}, 32'(logQ.size()), 32'(expQ.size()));
        n = (logQ.size() < expQ.size()) ? logQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_event%0d", tag, i), 32'(logQ[i]), 32'(expQ[i]));
        logQ.delete();
        expQ.delete();
    endtask

    task automatic applyStimulus(logic v, int d, logic l);
        tValid = v;
        tData  = 8'(d);
        tLast  = l;
        @(posedge clk);
        #1;
        tValid = 1'b0;
        tLast  = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) applyStimulus(1'b0, 0, 1'b0);
    endtask

    task automatic sendStream(int lo, int hi, bit gap);
        for (int v = lo; v <= hi; v++) begin
            applyStimulus(1'b1, v, v == hi);
            if (gap) applyStimulus(1'b0, 0, 1'b0);
        end
    endtask

    task automatic checkIdleOutputs(string tag);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput($sformatf("%s_valid%0d", tag, s), 32'(obsValid), 32'd0);
            checkOutput($sformatf("%s_done%0d", tag, s), 32'(obsDone), 32'd0);
            checkOutput($sformatf("%s_err%0d", tag, s), 32'(obsErr), 32'd0);
            checkOutput($sformatf("%s_ready%0d", tag, s), 32'(obsReady), 32'd1);
            checkOutput($sformatf("%s_win%0d", tag, s), 32'(obsWin), 32'd0);
        end
    endtask

    initial begin
        sel    = 0;
        tValid = 1'b0;
        tData  = 8'h0;
        tLast  = 1'b0;
        rst_n  = 1'b0;

        // Reset held for two cycles, then released.
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("rst_hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkIdleOutputs("rst_release");

        // PAD=0, STRIDE=1: seven windows, first one the cycle after sample 4.
        sel = 0;
        #1;
        logQ.delete();
        applyStimulus(1'b1, 2, 1'b0);
        applyStimulus(1'b1, 3, 1'b0);
        checkOutput("t1_no_window_yet", 32'(obsValid), 32'd0);
        applyStimulus(1'b1, 4, 1'b0);
        checkOutput("t1_first_valid", 32'(obsValid), 32'd1);
        checkOutput("t1_first_win", 32'(obsWin), 32'h020304);
        for (int v = 5; v <= 10; v++) applyStimulus(1'b1, v, v == 10);
        checkOutput("t1_last_done", 32'(obsDone), 32'd1);
        checkOutput("t1_last_win", 32'(obsWin), 32'h08090a);
        idle(4);
        for (int k = 2; k <= 8; k++) expQ.push_back(ent(1, k == 8, 0, k, k + 1, k + 2));
        checkLog("t1");

        // PAD=1, STRIDE=1: nine windows with leading and trailing zero pads.
        sel = 1;
        #1;
        logQ.delete();
        readyLow = 0;
        sendStream(2, 10, 1'b0);
        checkOutput("t2_flush_not_ready", 32'(obsReady), 32'd0);
        idle(4);
        checkOutput("t2_ready_low_cycles", 32'(readyLow), 32'd1);
        expQ.push_back(ent(1, 0, 0, 0, 2, 3));
        for (int k = 2; k <= 8; k++) expQ.push_back(ent(1, 0, 0, k, k + 1, k + 2));
        expQ.push_back(ent(1, 1, 0, 9, 10, 0));
        checkLog("t2");

        // PAD=0, STRIDE=2: the second sequence restarts its phase.
        sel = 2;
        #1;
        logQ.delete();
        sendStream(2, 10, 1'b0);
        sendStream(1, 5, 1'b0);
        idle(4);
        expQ.push_back(ent(1, 0, 0, 2, 3, 4));
        expQ.push_back(ent(1, 0, 0, 4, 5, 6));
        expQ.push_back(ent(1, 0, 0, 6, 7, 8));
        expQ.push_back(ent(1, 1, 0, 8, 9, 10));
        expQ.push_back(ent(1, 0, 0, 1, 2, 3));
        expQ.push_back(ent(1, 1, 0, 3, 4, 5));
        checkLog("t3");

        // Short sequence: err_short with seq_done, then a normal sequence.
        sel = 0;
        #1;
        logQ.delete();
        sendStream(5, 6, 1'b0);
        checkOutput("t4_short_err", 32'(obsErr), 32'd1);
        checkOutput("t4_short_done", 32'(obsDone), 32'd1);
        checkOutput("t4_short_no_window", 32'(obsValid), 32'd0);
        idle(2);
        sendStream(1, 3, 1'b0);
        idle(3);
        expQ.push_back(ent(0, 1, 1, 0, 0, 0));
        expQ.push_back(ent(1, 1, 0, 1, 2, 3));
        checkLog("t4");

        // Gapped stream gives the same seven windows.
        sendStream(2, 10, 1'b1);
        idle(3);
        for (int k = 2; k <= 8; k++) expQ.push_back(ent(1, k == 8, 0, k, k + 1, k + 2));
        checkLog("t5_gaps");

        // Reset after sample 5 drops the partial sequence and its seq_done.
        sendStream(2, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", 32'(obsValid), 32'd0);
        checkOutput("t5_rst_win", 32'(obsWin), 32'd0);
        checkOutput("t5_rst_ready", 32'(obsReady), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        sendStream(7, 9, 1'b0);
        idle(3);
        expQ.push_back(ent(1, 0, 0, 2, 3, 4));
        expQ.push_back(ent(1, 1, 0, 7, 8, 9));
        checkLog("t5_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
